// File: rtl/sd_wr_sched.sv
// sd_wr_sched -- multi-sector write scheduler for the SPI-mode SD write engine.
//
// Takes a job of N consecutive sectors from a base address and feeds the
// single-block write engine one request at a time. It waits for each block to
// complete, inserts GAP_CYC idle cycles, then issues the next sector.
//
// Optional feature macro: SD_WR_TIMEOUT_EN. When it is defined, a watchdog in
// WAIT_ACK/WAIT_DONE ends a stuck job with job_err. When it is undefined,
// job_err is tied low and the TIMEOUT_CYC parameter does not exist.
//
// Ports:
//   clk_25m, rst        clock, synchronous active-high reset
//   sd_init_done        card ready; job_start is ignored while low
//   job_start           pulse; samples job_sec_base / job_sec_num
//   job_abort           pulse; the job stops at the next sector boundary
//   job_busy/job_done   job status; job_done is a one-cycle end pulse
//   job_err             one-cycle pulse with job_done on watchdog expiry
//   sec_done_cnt        sectors completed in the current/last job
//   wr_start_en, sec    request to engine, held until wr_busy is seen
//   wr_busy             engine busy / acknowledge
//   sd_block_wdone      engine block-done level (rising edge = block done)
module sd_wr_sched #(
  parameter int CNT_W   = 16,
  parameter int GAP_CYC = 8     // must be >= 1
`ifdef SD_WR_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 25_000_000
`endif
) (
  input  logic             clk_25m,
  input  logic             rst,
  input  logic             sd_init_done,
  input  logic             job_start,
  input  logic [31:0]      job_sec_base,
  input  logic [CNT_W-1:0] job_sec_num,
  input  logic             job_abort,
  output logic             job_busy,
  output logic             job_done,
  output logic             job_err,
  output logic [CNT_W-1:0] sec_done_cnt,
  output logic             wr_start_en,
  output logic [31:0]      sec,
  input  logic             wr_busy,
  input  logic             sd_block_wdone
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_GAP, S_FINISH
  } state_e;

  state_e           state_q;
  logic [31:0]      cur_sec_q;
  logic [CNT_W-1:0] remaining_q;
  logic [15:0]      gap_q;
  logic             abort_q;
  logic             wdone_q;
  logic             job_busy_q, job_done_q, wr_start_en_q;
  logic [31:0]      sec_q;
  logic [CNT_W-1:0] sec_done_cnt_q;

  // The engine holds done high between blocks, so only a rising edge counts.
  logic             done_edge;
  logic [CNT_W-1:0] rem_dec;
  assign done_edge = sd_block_wdone & ~wdone_q;
  assign rem_dec   = remaining_q - CNT_W'(1);

`ifdef SD_WR_TIMEOUT_EN
  logic [31:0] wd_q;
  logic        job_err_q;
  logic        wd_hit;
  assign wd_hit  = (wd_q == 32'(TIMEOUT_CYC - 1));
  assign job_err = job_err_q;
`else
  assign job_err = 1'b0;
`endif

  always_ff @(posedge clk_25m) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cur_sec_q      <= '0;
      remaining_q    <= '0;
      gap_q          <= '0;
      abort_q        <= 1'b0;
      wdone_q        <= 1'b0;
      job_busy_q     <= 1'b0;
      job_done_q     <= 1'b0;
      wr_start_en_q  <= 1'b0;
      sec_q          <= '0;
      sec_done_cnt_q <= '0;
`ifdef SD_WR_TIMEOUT_EN
      wd_q           <= '0;
      job_err_q      <= 1'b0;
`endif
    end else begin
      wdone_q    <= sd_block_wdone;
      job_done_q <= 1'b0;
`ifdef SD_WR_TIMEOUT_EN
      job_err_q  <= 1'b0;
`endif
      // Sticky abort; it is only acted on at a sector boundary.
      if (state_q != S_IDLE && job_abort) abort_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (job_start && sd_init_done) begin
            cur_sec_q      <= job_sec_base;
            remaining_q    <= job_sec_num;
            sec_done_cnt_q <= '0;
            abort_q        <= 1'b0;
            job_busy_q     <= 1'b1;
            state_q        <= (job_sec_num == '0) ? S_FINISH : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!wr_busy) begin
            sec_q         <= cur_sec_q;
            wr_start_en_q <= 1'b1;
            state_q       <= S_WAIT_ACK;
`ifdef SD_WR_TIMEOUT_EN
            wd_q          <= '0;
`endif
          end
        end
        S_WAIT_ACK: begin
          if (wr_busy) begin
            wr_start_en_q <= 1'b0;
            state_q       <= S_WAIT_DONE;
`ifdef SD_WR_TIMEOUT_EN
            wd_q          <= '0;
          end else if (wd_hit) begin
            wr_start_en_q <= 1'b0;
            job_err_q     <= 1'b1;
            job_done_q    <= 1'b1;
            job_busy_q    <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            wd_q          <= wd_q + 32'd1;
`endif
          end
        end
        S_WAIT_DONE: begin
          if (done_edge) begin
            cur_sec_q      <= cur_sec_q + 32'd1;
            sec_done_cnt_q <= sec_done_cnt_q + CNT_W'(1);
            remaining_q    <= rem_dec;
            gap_q          <= '0;
            // A done edge coinciding with job_abort still ends the job here.
            state_q        <= (rem_dec == '0 || abort_q || job_abort) ? S_FINISH : S_GAP;
`ifdef SD_WR_TIMEOUT_EN
          end else if (wd_hit) begin
            wr_start_en_q <= 1'b0;
            job_err_q     <= 1'b1;
            job_done_q    <= 1'b1;
            job_busy_q    <= 1'b0;
            state_q       <= S_IDLE;
          end else begin
            wd_q          <= wd_q + 32'd1;
`endif
          end
        end
        S_GAP: begin
          if (gap_q == 16'(GAP_CYC - 1)) state_q <= S_ISSUE;
          else                           gap_q   <= gap_q + 16'd1;
        end
        S_FINISH: begin
          job_done_q <= 1'b1;
          job_busy_q <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign job_busy     = job_busy_q;
  assign job_done     = job_done_q;
  assign wr_start_en  = wr_start_en_q;
  assign sec          = sec_q;
  assign sec_done_cnt = sec_done_cnt_q;

endmodule
